// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: serves 32-bit words from a synchronous backing memory
// through a one-word buffer, inserting WAIT_STATES idle cycles before each read.
module inst_fetch_resp #(
    parameter int WAIT_STATES    = 2,
    parameter int MEM_DEPTH_LOG2 = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic [31:0]               addr,
    output logic [31:0]               inst,
    output logic                      inst_valid,
    output logic                      stallreq,
    output logic                      err,
    output logic                      mem_re,
    output logic [MEM_DEPTH_LOG2-1:0] mem_addr,
    input  logic [31:0]               mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_READ = 2'd2,
        ST_FILL = 2'd3
    } state_e;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_addr_q, buf_addr_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic        aligned_s;
    logic        hit_s;

    // Fetch-side outputs; the buffer compare runs in every state so hits bypass a busy FSM.
    always_comb begin
        aligned_s  = (addr[1:0] == 2'b00);
        hit_s      = buf_valid_q && (buf_addr_q == addr);
        err        = rst && ce && !aligned_s;
        inst_valid = ce && hit_s && aligned_s;
        inst       = inst_valid ? buf_data_q : 32'h0000_0000;
        stallreq   = rst && ce && !hit_s && aligned_s;
        mem_re     = (state_q == ST_READ);
        mem_addr   = req_addr_q[MEM_DEPTH_LOG2+1:2];
    end

    // Next-state logic; an in-flight fetch always runs to completion (no abort path).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_addr_d  = req_addr_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        case (state_q)
            ST_IDLE: begin
                if (stallreq) begin
                    req_addr_d = addr;
                    cnt_d      = WAIT_CNT;
                    if (WAIT_CNT != 4'd0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_READ: begin
                state_d = ST_FILL;
            end
            ST_FILL: begin
                buf_data_d  = mem_rdata;
                buf_addr_d  = req_addr_q;
                buf_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and buffer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            req_addr_q  <= 32'h0000_0000;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= 32'h0000_0000;
            buf_data_q  <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_addr_q  <= req_addr_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
        end
    end

endmodule

// File: doc/inst_fetch_resp.md
# inst_fetch_resp

Responder end of the instruction-fetch interface driven by the program counter register. Accepts `ce`/`addr` from the PC stage and returns a 32-bit instruction from a synchronous backing ROM/RAM. It inserts a configurable number of wait states and holds one fetched word in a buffer. While the requested word is not yet available it raises `stallreq`, which the stall controller folds into `stall[0]` so the PC holds.

## Interface
- `WAIT_STATES`, default 2: extra wait cycles before each backing-memory read; legal range 0..15.
- `MEM_DEPTH_LOG2`, default 10: log2 of backing-memory depth in words.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset. 0 = reset.
- `ce` in 1: fetch enable from the PC stage. 1 = `addr` is a live request.
- `addr` in 32: byte address of the requested instruction.
- `inst` out 32: instruction word; 32'h00000000 (NOP) when `inst_valid`=0.
- `inst_valid` out 1: `inst` holds the word at `addr`.
- `stallreq` out 1: PC/IF must hold; request not yet served.
- `err` out 1: misaligned request (`addr[1:0]` != 0) while `ce`=1.
- `mem_re` out 1: backing-memory read strobe.
- `mem_addr` out MEM_DEPTH_LOG2: word address, equal to `req_addr[MEM_DEPTH_LOG2+1:2]`.
- `mem_rdata` in 32: backing-memory data, valid the cycle after `mem_re`=1.

## Operation
Registered state:
- FSM state
- wait counter, 4 bits
- `req_addr`, 32 bits
- `buf_valid`, `buf_addr` (32 bits), `buf_data` (32 bits)

Combinational signals:
- `hit` = `buf_valid` & (`buf_addr` == `addr`).
- `inst_valid` = `ce` & `hit` & aligned. `inst` = `buf_data` when `inst_valid`, else 0.
- `err` = `ce` & (`addr[1:0]` != 0).
- `stallreq` = `ce` & ~`hit` & ~`err`. Forced to 0 while `rst`=0.
- `hit` is evaluated in every state, so a buffered word is returned even while the FSM is busy.

FSM states:
- IDLE: if `ce` & ~`hit` & ~`err`:
  - latch `req_addr`=`addr` and counter=`WAIT_STATES`;
  - go to WAIT if `WAIT_STATES`>0, else go to READ.
  - Otherwise stay in IDLE.
- WAIT: decrement the counter. When the counter equals 1, go to READ.
- READ: `mem_re`=1 with `mem_addr` from `req_addr`. Go to FILL.
- FILL: `buf_data` <= `mem_rdata`, `buf_addr` <= `req_addr`, `buf_valid` <= 1. Go to IDLE.

Boundary conditions:
- `addr` changes mid-fetch (branch/flush): the in-flight fetch completes for the old `req_addr` and fills the buffer. IDLE then sees a miss and starts a new fetch. No abort path.
- `ce` drops mid-fetch: the fetch completes and the buffer fills. Outputs show `inst`=0, `stallreq`=0.
- Misaligned request: no fetch starts, buffer unchanged, `inst`=0, `stallreq`=0, `err`=1.
- Upper address bits above `MEM_DEPTH_LOG2+1` are ignored for `mem_addr` (addresses alias), but take part in the `hit` compare.
- `mem_re` is asserted only in READ. `mem_addr` is driven from `req_addr` in all states.

## Timing
- Reset (`rst`=0, asynchronous):
  - state=IDLE, counter=0, `req_addr`=0, `buf_valid`=0, `buf_addr`=0, `buf_data`=0;
  - `inst`=0, `inst_valid`=0, `stallreq`=0, `err`=0, `mem_re`=0, `mem_addr`=0.
- Release is sampled at the first rising edge after `rst` goes high.
- Miss penalty: a miss detected in cycle 0 keeps `stallreq` high for exactly `WAIT_STATES`+3 cycles (cycles 0..W+2).
  - The buffer updates at the edge ending cycle W+2.
  - `inst_valid`=1 and `stallreq`=0 from cycle W+3.
- Hit: zero latency. `inst` and `inst_valid` follow `addr` combinationally in the same cycle.
- Sequential PC (+4 each cycle) misses on every new word. Steady-state throughput is one instruction per `WAIT_STATES`+4 cycles.
- Reset asserted mid-fetch: everything clears immediately. No `mem_re` is issued after reset assertion.

## Test plan
- Reset: hold `rst`=0 with `ce`=1, `addr`=0 -> all outputs 0. Release; `mem` word0=32'h34011100, W=2 -> `stallreq`=1 for 5 cycles, `mem_re`=1 in the 4th, then `inst`=32'h34011100 and `inst_valid`=1.
- Hit: hold `addr`=0 for 3 more cycles -> `inst` stable, `stallreq`=0, no further `mem_re`.
- Sequence 0,4,8 with PC stalled by `stallreq`:
  - each address takes 5 stall cycles;
  - `mem_addr` = 0, 1, 2;
  - `inst` matches words 0..2.
- Branch mid-fetch: `addr` 4 -> 32'h40 in a WAIT cycle -> buffer fills with word1, then a new fetch with `mem_addr`=16, then `inst`=word16.
- Misaligned: `addr`=32'h6, `ce`=1 -> `err`=1, `inst`=0, `stallreq`=0, no `mem_re`. `ce`=0 -> `err`=0.
- Async reset in READ -> outputs 0 immediately, `buf_valid`=0. The next request to the same address misses.
